// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_STAGES reset domains in order, each gated by the
// previous stage's ready, with per-stage timeout and software re-sequence.
module reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int KW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  localparam int CW = $clog2(((HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES) + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  por,
  input  logic                  sw_reset_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  seq_done,
  output logic                  seq_error,
  output logic [KW-1:0]         error_stage
);
  typedef enum logic [1:0] {HOLD, WAIT, DONE, ERROR} state_t;
  state_t                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d, es_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]   rst_d;
  logic                    done_d, err_d, restart;
  assign restart = por || (sw_reset_req && (state_q == DONE || state_q == ERROR));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HOLD;
      k_q         <= '0;
      cnt_q       <= '0;
      stage_rst   <= '1;
      seq_done    <= 1'b0;
      seq_error   <= 1'b0;
      error_stage <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      stage_rst   <= rst_d;
      seq_done    <= done_d;
      seq_error   <= err_d;
      error_stage <= es_d;
    end
  end
  // Releasing the next stage is a zero-fill left shift of the reset vector.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    rst_d   = stage_rst;
    done_d  = seq_done;
    err_d   = seq_error;
    es_d    = error_stage;
    if (restart) begin
      state_d = HOLD;
      k_d     = '0;
      cnt_d   = '0;
      rst_d   = '1;
      done_d  = 1'b0;
      err_d   = 1'b0;
      es_d    = '0;
    end else if (state_q == HOLD) begin
      if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
        state_d = WAIT;
        k_d     = '0;
        cnt_d   = '0;
        rst_d   = stage_rst << 1;
      end else
        cnt_d = cnt_q + 1'b1;
    end else if (state_q == WAIT) begin
      if (stage_ready[k_q]) begin
        cnt_d = '0;
        if (k_q == KW'(NUM_STAGES - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          k_d   = k_q + 1'b1;
          rst_d = stage_rst << 1;
        end
      end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d = ERROR;
        cnt_d   = '0;
        rst_d   = '1;
        err_d   = 1'b1;
        es_d    = k_q;
      end else
        cnt_d = cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench; stimulus queues edge-tagged expectations,
// a monitor pops and compares them at the falling edge after each tagged clock edge.
module tb_reset_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, por, sw_reset_req;
  logic [2:0] stage_ready, stage_rst;
  logic       seq_done, seq_error;
  logic [1:0] error_stage;
  int         edge_n = 0;
  int         vectors = 0;
  int         miscompares = 0;
  typedef struct {
    int         e;
    logic [2:0] r;
    logic       d;
    logic       er;
    logic [1:0] es;
  } exp_t;
  exp_t sb[$];

  reset_sequencer #(.NUM_STAGES(3), .HOLD_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .por(por), .sw_reset_req(sw_reset_req),
    .stage_ready(stage_ready), .stage_rst(stage_rst), .seq_done(seq_done),
    .seq_error(seq_error), .error_stage(error_stage)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].e <= edge_n) begin
      exp_t x;
      x = sb.pop_front();
      vectors++;
      if (x.e != edge_n || stage_rst !== x.r || seq_done !== x.d ||
          seq_error !== x.er || (x.er && error_stage !== x.es) || (!x.er && error_stage !== 2'd0)) begin
        miscompares++;
        $display("FAIL edge%0d: got rst=%b done=%b err=%b es=%0d, expected rst=%b done=%b err=%b es=%0d (edge %0d)",
                 edge_n, stage_rst, seq_done, seq_error, error_stage, x.r, x.d, x.er, x.es, x.e);
      end
    end
  end

  task automatic exp_at(input int e, input logic [2:0] r, input logic d, input logic er, input logic [1:0] es);
    exp_t x;
    x.e = e; x.r = r; x.d = d; x.er = er; x.es = es;
    sb.push_back(x);
  endtask

  task automatic wait_edge(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations never reached, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic por_pulse(output int b);
    por = 1'b1;
    @(negedge clk);
    por = 1'b0;
    b = edge_n + 1;
  endtask

  initial begin
    int b, b2, y;
    rst_n = 1'b0; por = 1'b1; sw_reset_req = 1'b0; stage_ready = 3'b111;
    // power-up with ready tied high, por held first
    @(negedge clk);
    exp_at(edge_n + 1, 3'b111, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_at(edge_n + 2, 3'b111, 0, 0, 0);
    @(negedge clk); @(negedge clk);
    por = 1'b0;
    b = edge_n + 1;
    exp_at(b + 2, 3'b111, 0, 0, 0);
    exp_at(b + 3, 3'b110, 0, 0, 0);
    exp_at(b + 4, 3'b100, 0, 0, 0);
    exp_at(b + 5, 3'b000, 0, 0, 0);
    exp_at(b + 6, 3'b000, 1, 0, 0);
    drain();
    // sw_reset_req in DONE re-runs the sequence
    sw_reset_req = 1'b1;
    b = edge_n + 1;
    exp_at(b, 3'b111, 0, 0, 0);
    exp_at(b + 3, 3'b111, 0, 0, 0);
    exp_at(b + 4, 3'b110, 0, 0, 0);
    exp_at(b + 5, 3'b100, 0, 0, 0);
    exp_at(b + 6, 3'b000, 0, 0, 0);
    exp_at(b + 7, 3'b000, 1, 0, 0);
    @(negedge clk);
    sw_reset_req = 1'b0;
    drain();
    // delayed ack on stage 1, stray ready[2] and sw pulse in WAIT(1) ignored
    stage_ready = 3'b101;
    por_pulse(b);
    exp_at(b + 2, 3'b111, 0, 0, 0);
    exp_at(b + 3, 3'b110, 0, 0, 0);
    exp_at(b + 4, 3'b100, 0, 0, 0);
    exp_at(b + 9, 3'b100, 0, 0, 0);
    exp_at(b + 13, 3'b100, 0, 0, 0);
    exp_at(b + 14, 3'b000, 0, 0, 0);
    exp_at(b + 15, 3'b000, 1, 0, 0);
    wait_edge(b + 7);
    sw_reset_req = 1'b1;
    @(negedge clk);
    sw_reset_req = 1'b0;
    wait_edge(b + 13);
    stage_ready = 3'b111;
    drain();
    // timeout on stage 1, ERROR holds, sw_reset_req recovers
    stage_ready = 3'b001;
    por_pulse(b);
    exp_at(b + 4, 3'b100, 0, 0, 0);
    exp_at(b + 19, 3'b100, 0, 0, 0);
    exp_at(b + 20, 3'b111, 0, 1, 1);
    exp_at(b + 25, 3'b111, 0, 1, 1);
    drain();
    sw_reset_req = 1'b1;
    b = edge_n + 1;
    exp_at(b, 3'b111, 0, 0, 0);
    exp_at(b + 4, 3'b110, 0, 0, 0);
    exp_at(b + 5, 3'b100, 0, 0, 0);
    @(negedge clk);
    sw_reset_req = 1'b0;
    drain();
    // ready[1] on the final sample edge wins; stage 2 then times out
    por_pulse(b);
    exp_at(b + 19, 3'b100, 0, 0, 0);
    exp_at(b + 20, 3'b000, 0, 0, 0);
    exp_at(b + 21, 3'b000, 0, 0, 0);
    exp_at(b + 35, 3'b000, 0, 0, 0);
    exp_at(b + 36, 3'b111, 0, 1, 2);
    wait_edge(b + 19);
    stage_ready = 3'b011;
    drain();
    // por pulse while in WAIT(2)
    por_pulse(b);
    exp_at(b + 3, 3'b110, 0, 0, 0);
    exp_at(b + 4, 3'b100, 0, 0, 0);
    exp_at(b + 5, 3'b000, 0, 0, 0);
    exp_at(b + 8, 3'b111, 0, 0, 0);
    wait_edge(b + 7);
    por_pulse(b2);
    exp_at(b2 + 2, 3'b111, 0, 0, 0);
    exp_at(b2 + 3, 3'b110, 0, 0, 0);
    exp_at(b2 + 6, 3'b000, 0, 0, 0);
    wait_edge(b2 + 6);
    // asynchronous rst_n mid-cycle
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_at(edge_n, 3'b111, 0, 0, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    y = edge_n;
    exp_at(y + 3, 3'b111, 0, 0, 0);
    exp_at(y + 4, 3'b110, 0, 0, 0);
    exp_at(y + 5, 3'b100, 0, 0, 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Ordered reset-release controller for the CPLD. Takes the synchronous power-on reset from the reliable-clock reset generator and releases a set of downstream reset domains one at a time. Each stage is released only after the previous stage acknowledges ready, with a per-stage timeout and a software-requested re-sequence. It sits between the power-on reset generator and the per-subsystem reset inputs (ctrlport, SPI, power-control logic).

## Interface
- NUM_STAGES, 4: number of sequenced reset domains, legal 1..8.
- HOLD_CYCLES, 16: cycles all stages are held in reset before the first release, legal ≥1.
- TIMEOUT_CYCLES, 1024: maximum cycles to wait for a stage's ready, legal ≥1.
- Clock: clk, input, 1: reliable clock; all logic on rising edge.
- Reset: rst_n, input, 1: asynchronous, active-low reset.
- por, input, 1: synchronous active-high power-on reset.
- sw_reset_req, input, 1: single-cycle request to re-run the sequence.
- stage_ready, input, NUM_STAGES: per-stage acknowledge. Synchronous to clk; cross-domain acknowledges are synchronized upstream.
- stage_rst, output, NUM_STAGES: active-high reset per stage. Bit 0 is released first.
- seq_done, output, 1: all stages released and acknowledged.
- seq_error, output, 1: a stage timed out.
- error_stage, output, max(1,$clog2(NUM_STAGES)): index of the stage that timed out. Valid while seq_error=1.

## Operation
- Reset values (rst_n=0): stage_rst all ones, seq_done=0, seq_error=0, error_stage=0, state HOLD, counter=0.
- States: HOLD, WAIT(k), DONE, ERROR.
- HOLD
  - All stage_rst=1.
  - The counter increments each cycle.
  - When counter reaches HOLD_CYCLES-1: clear stage_rst[0], clear counter, go to WAIT(0).
- WAIT(k)
  - stage_rst[k:0]=0; higher stages stay 1.
  - Ready handling: if stage_ready[k]=1 and k<NUM_STAGES-1, clear stage_rst[k+1], clear counter, go to WAIT(k+1).
  - If stage_ready[k]=1 and k=NUM_STAGES-1, go to DONE and set seq_done=1.
  - Timeout: otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 with ready still low, go to ERROR.
  - On entering ERROR: set seq_error=1, set error_stage=k, re-assert stage_rst[k] (all stages back in reset).
  - Only stage_ready[k] is examined. Other ready bits are ignored.
- DONE
  - Outputs hold.
  - stage_ready changes are ignored.
- ERROR
  - Outputs hold; stays until restart.
- Restart
  - Trigger: por=1 in any state, or sw_reset_req=1 in DONE or ERROR.
  - Action: next edge sets all stage_rst=1, clears seq_done, seq_error and error_stage, clears counter, enters HOLD.
  - sw_reset_req in HOLD or WAIT is ignored, not queued.
  - por=1 held: remain in HOLD with counter held at 0. Counting starts on the first edge with por=0.
  - por and sw_reset_req together: identical result to por.
- Counter width: $clog2(max(HOLD_CYCLES,TIMEOUT_CYCLES)+1). It never wraps, because it clears on every transition.

## Timing
- All outputs are registered; no combinational path from input to output.
- Release to first sample: stage_rst[k] falls at edge e. stage_ready[k] is first sampled at edge e+1.
- Ready to next release: stage_ready[k] sampled high at edge n makes stage_rst[k+1] (or seq_done) change at edge n.
- Minimum stage-to-stage spacing is one cycle.
- Hold length: with por falling before edge p, stage_rst[0] falls at edge p+HOLD_CYCLES-1.
- Timeout length: ERROR is entered at edge e+TIMEOUT_CYCLES, where e is the release edge of the stage.
- Ready arrival: ready sampled high at edge e+TIMEOUT_CYCLES is accepted; ready beats timeout on the same edge.
- rst_n assertion is asynchronous and forces reset values immediately. Deassertion is synchronized externally; the block starts in HOLD.

## Test plan
Configuration for all scenarios: NUM_STAGES=3, HOLD_CYCLES=4, TIMEOUT_CYCLES=16.
- Power-up, ready tied high: rst_n release then por falling before edge 0 → stage_rst 111, then 110 at edge 3, 100 at edge 4, 000 at edge 5. seq_done=1 at edge 6.
- Delayed ack: stage_ready[1] asserted 10 cycles after stage_rst[1] falls → stage_rst[2] falls on that sample edge. seq_error stays 0.
- Timeout: stage_ready[1] held low → ERROR 16 edges after stage_rst[1] falls. Results: seq_error=1, error_stage=1, stage_rst=111, seq_done=0.
- Ready/timeout race: stage_ready[1] rises exactly at the 16th sample edge → accepted; no error.
- sw_reset_req pulse in DONE → stage_rst=111 and seq_done=0 next edge, then a full sequence repeats. The same pulse during WAIT(1) → no effect.
- por pulse mid-sequence (in WAIT(2)) → all stages reasserted next edge, HOLD restarts. The same holds when rst_n is asserted asynchronously mid-cycle → outputs take reset values immediately.
